// File: rtl/noc_loopback_pkg.sv
// Shared definitions for the NoC loopback endpoint: default header field
// positions, the per-lane debug state encoding and the header swap helper.
package noc_loopback_pkg;

    localparam int HDR_FLIT_WIDTH  = 32;
    localparam int HDR_DEST_LSB    = 27;
    localparam int HDR_SRC_LSB     = 19;
    localparam int HDR_ID_WIDTH    = 5;
    localparam int PKT_COUNT_WIDTH = 16;
    localparam logic [PKT_COUNT_WIDTH-1:0] PKT_COUNT_MAX = '1;

    // Lane condition derived from (empty, pkts_stored, draining).
    typedef enum logic [1:0] {
        LB_IDLE  = 2'd0,  // nothing buffered
        LB_FILL  = 2'd1,  // partial packet buffered, output held back
        LB_READY = 2'd2,  // a whole packet is buffered, or the buffer is full
        LB_DRAIN = 2'd3   // a packet is part-way out, stream the rest
    } loopback_state_e;

    // Return a header flit whose destination field carries the source ID,
    // using the default field positions.
    function automatic logic [HDR_FLIT_WIDTH-1:0] hdr_swap(
        input logic [HDR_FLIT_WIDTH-1:0] flit
    );
        logic [HDR_FLIT_WIDTH-1:0] swapped;
        swapped = flit;
        swapped[HDR_DEST_LSB +: HDR_ID_WIDTH] = flit[HDR_SRC_LSB +: HDR_ID_WIDTH];
        return swapped;
    endfunction

endpackage

// File: rtl/noc_loopback_fifo.sv
// One loopback lane: store-and-forward flit buffer with a cut-through release
// when full, packet bookkeeping and the header destination rewrite.
module noc_loopback_fifo
    import noc_loopback_pkg::*;
#(
    parameter int FLIT_WIDTH = HDR_FLIT_WIDTH,
    parameter int DEPTH      = 16,
    parameter int DEST_LSB   = HDR_DEST_LSB,
    parameter int SRC_LSB    = HDR_SRC_LSB,
    parameter int ID_WIDTH   = HDR_ID_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [FLIT_WIDTH-1:0] in_flit,
    input  logic                  in_last,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [FLIT_WIDTH-1:0] out_flit,
    output logic                  out_last,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  pkt_done
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam int CNT_W  = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

    logic [FLIT_WIDTH:0]   mem [DEPTH];
    logic [ADDR_W-1:0]     wptr;
    logic [ADDR_W-1:0]     rptr;
    logic [CNT_W-1:0]      occupancy;
    logic [CNT_W-1:0]      occ_next;
    logic [CNT_W-1:0]      pkts_stored;
    logic                  draining;
    logic                  out_first;
    logic                  in_ready_q;
    logic                  wr_en;
    logic                  rd_en;
    logic                  empty;
    logic                  full;
    logic [FLIT_WIDTH-1:0] rd_flit;
    loopback_state_e       state;

    assign empty    = (occupancy == '0);
    assign full     = (occupancy == DEPTH_CNT);
    assign in_ready = in_ready_q;
    assign wr_en    = in_valid && in_ready_q;
    assign rd_en    = out_valid && out_ready;
    assign pkt_done = rd_en && out_last;

    assign {out_last, rd_flit} = mem[rptr];

    // Classify the lane; a partial packet is held back unless the buffer is
    // full (cut-through so long packets cannot deadlock) or already draining.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        state = LB_IDLE;
        if (empty) begin
            state = LB_IDLE;
        end else if (draining) begin
            state = LB_DRAIN;
        end else if ((pkts_stored != '0) || full) begin
            state = LB_READY;
        end else begin
            state = LB_FILL;
        end
    end

    assign out_valid = (state == LB_READY) || (state == LB_DRAIN);

    // Occupancy after this edge; also decides the registered in_ready.
    always_comb begin
        occ_next = occupancy;
        case ({wr_en, rd_en})
            2'b10:   occ_next = occupancy + CNT_W'(1);
            2'b01:   occ_next = occupancy - CNT_W'(1);
            default: occ_next = occupancy;
        endcase
    end

    // Header flits leave with the destination field replaced by the source field.
    always_comb begin
        out_flit = rd_flit;
        if (out_first) begin
            out_flit[DEST_LSB +: ID_WIDTH] = rd_flit[SRC_LSB +: ID_WIDTH];
        end
    end

    // Flit storage, written at wptr on every accepted input flit.
    always_ff @(posedge clk) begin
        // NOTE: the array has no reset; pointers and occupancy alone say which entries are live.
        if (wr_en) begin
            mem[wptr] <= {in_last, in_flit};
        end
    end

    // Pointers, counters and packet-boundary flags; reset drops everything buffered.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) begin
            wptr        <= '0;
            rptr        <= '0;
            occupancy   <= '0;
            pkts_stored <= '0;
            draining    <= 1'b0;
            out_first   <= 1'b1;
            in_ready_q  <= 1'b0;
        end else begin
            occupancy  <= occ_next;
            in_ready_q <= (occ_next < DEPTH_CNT);
            if (wr_en) begin
                wptr <= wptr + ADDR_W'(1);
            end
            if (rd_en) begin
                rptr      <= rptr + ADDR_W'(1);
                out_first <= out_last;
            end
            case ({wr_en && in_last, rd_en && out_last})
                2'b10:   pkts_stored <= pkts_stored + CNT_W'(1);
                2'b01:   pkts_stored <= pkts_stored - CNT_W'(1);
                default: pkts_stored <= pkts_stored;
            endcase
            if (rd_en && out_last) begin
                draining <= 1'b0;
            end else if (rd_en && out_first) begin
                draining <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/noc_loopback_endpoint.sv
// Loopback partner for a single compute tile: every packet the tile sends on a
// channel comes back on the same channel addressed to its sender.
module noc_loopback_endpoint
    import noc_loopback_pkg::*;
#(
    parameter int CHANNELS   = 2,
    parameter int FLIT_WIDTH = HDR_FLIT_WIDTH,
    parameter int DEPTH      = 16,
    parameter int DEST_LSB   = HDR_DEST_LSB,
    parameter int SRC_LSB    = HDR_SRC_LSB,
    parameter int ID_WIDTH   = HDR_ID_WIDTH
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [CHANNELS*FLIT_WIDTH-1:0] in_flit,
    input  logic [CHANNELS-1:0]            in_last,
    input  logic [CHANNELS-1:0]            in_valid,
    output logic [CHANNELS-1:0]            in_ready,
    output logic [CHANNELS*FLIT_WIDTH-1:0] out_flit,
    output logic [CHANNELS-1:0]            out_last,
    output logic [CHANNELS-1:0]            out_valid,
    input  logic [CHANNELS-1:0]            out_ready,
    output logic [CHANNELS*16-1:0]         pkt_count
);

    for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_lane
        logic                       pkt_done;
        logic [PKT_COUNT_WIDTH-1:0] pkt_cnt_q;

        noc_loopback_fifo #(
            .FLIT_WIDTH (FLIT_WIDTH),
            .DEPTH      (DEPTH),
            .DEST_LSB   (DEST_LSB),
            .SRC_LSB    (SRC_LSB),
            .ID_WIDTH   (ID_WIDTH)
        ) u_fifo (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_flit   (in_flit[ch*FLIT_WIDTH +: FLIT_WIDTH]),
            .in_last   (in_last[ch]),
            .in_valid  (in_valid[ch]),
            .in_ready  (in_ready[ch]),
            .out_flit  (out_flit[ch*FLIT_WIDTH +: FLIT_WIDTH]),
            .out_last  (out_last[ch]),
            .out_valid (out_valid[ch]),
            .out_ready (out_ready[ch]),
            .pkt_done  (pkt_done)
        );

        // Count packets fully handed back to the tile, sticking at the maximum.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                pkt_cnt_q <= '0;
            end else if (pkt_done && (pkt_cnt_q != PKT_COUNT_MAX)) begin
                pkt_cnt_q <= pkt_cnt_q + PKT_COUNT_WIDTH'(1);
            end
        end

        assign pkt_count[ch*16 +: 16] = pkt_cnt_q;
    end

endmodule

// File: tb/tb_noc_loopback_endpoint.sv
// Randomized bench for noc_loopback_endpoint. A negedge monitor keeps a
// packet-level model per channel (expected flit queue, occupancy, complete
// packets held, output mid-packet flag, packet counter) and checks every
// handshake, the ready/valid levels and output stability against it.
module tb_noc_loopback_endpoint;

    localparam int CH    = 2;
    localparam int FW    = 32;
    localparam int DEPTH = 16;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [CH*FW-1:0] in_flit = '0;
    logic [CH-1:0]    in_last = '0;
    logic [CH-1:0]    in_valid = '0;
    logic [CH-1:0]    in_ready;
    logic [CH*FW-1:0] out_flit;
    logic [CH-1:0]    out_last;
    logic [CH-1:0]    out_valid;
    logic [CH-1:0]    out_ready = '0;
    logic [CH*16-1:0] pkt_count;

    noc_loopback_endpoint #(
        .CHANNELS   (CH),
        .FLIT_WIDTH (FW),
        .DEPTH      (DEPTH),
        .DEST_LSB   (27),
        .SRC_LSB    (19),
        .ID_WIDTH   (5)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_flit   (in_flit),
        .in_last   (in_last),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_flit  (out_flit),
        .out_last  (out_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .pkt_count (pkt_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] flit;
        logic        last;
    } exp_t;

    exp_t        exp_q [CH][$];
    int          occ [CH];
    int          lasts [CH];
    bit          mid_out [CH];
    bit          in_first [CH];
    bit          stall_pend [CH];
    logic [31:0] stall_flit [CH];
    logic        stall_last [CH];
    logic [15:0] model_cnt [CH];
    int          rdy_mode [CH];
    bit          rst_last = 1'b1;
    bit          mon_en = 1'b0;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    initial begin
        for (int c = 0; c < CH; c++) begin
            occ[c] = 0; lasts[c] = 0; mid_out[c] = 0; in_first[c] = 1;
            stall_pend[c] = 0; model_cnt[c] = '0; rdy_mode[c] = 0;
        end
    end

    // Output ready pattern per channel: 0 hold low, 1 hold high, 2 random.
    always @(posedge clk) begin
        #1;
        for (int c = 0; c < CH; c++) begin
            case (rdy_mode[c])
                0:       out_ready[c] = 1'b0;
                1:       out_ready[c] = 1'b1;
                default: out_ready[c] = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Reference model: compare levels first, then apply the handshakes that
    // the coming rising edge will perform.
    always @(negedge clk) begin
        if (mon_en) begin
            for (int c = 0; c < CH; c++) begin
                bit   ov_exp;
                exp_t e;
                check($sformatf("pkt_count ch%0d", c), 32'(pkt_count[c*16 +: 16]), 32'(model_cnt[c]));
                check($sformatf("in_ready ch%0d", c), 32'(in_ready[c]), 32'(!rst_last && occ[c] < DEPTH));
                ov_exp = (occ[c] > 0) && (lasts[c] > 0 || occ[c] == DEPTH || mid_out[c]);
                check($sformatf("out_valid ch%0d", c), 32'(out_valid[c]), 32'(ov_exp));
                if (stall_pend[c]) begin
                    check($sformatf("stall_valid ch%0d", c), 32'(out_valid[c]), 32'd1);
                    check($sformatf("stall_flit ch%0d", c), out_flit[c*FW +: FW], stall_flit[c]);
                    check($sformatf("stall_last ch%0d", c), 32'(out_last[c]), 32'(stall_last[c]));
                end
                if (!rst_n) begin
                    exp_q[c].delete();
                    occ[c] = 0; lasts[c] = 0; mid_out[c] = 0; in_first[c] = 1;
                    stall_pend[c] = 0; model_cnt[c] = '0;
                end else begin
                    stall_pend[c] = out_valid[c] && !out_ready[c];
                    stall_flit[c] = out_flit[c*FW +: FW];
                    stall_last[c] = out_last[c];
                    if (out_valid[c] && out_ready[c]) begin
                        if (exp_q[c].size() == 0) begin
                            check($sformatf("unexpected_out ch%0d", c), 32'(out_valid[c]), 32'd0);
                        end else begin
                            e = exp_q[c].pop_front();
                            check($sformatf("out_flit ch%0d", c), out_flit[c*FW +: FW], e.flit);
                            check($sformatf("out_last ch%0d", c), 32'(out_last[c]), 32'(e.last));
                            occ[c]--;
                            if (e.last) begin
                                lasts[c]--;
                                mid_out[c] = 0;
                                if (model_cnt[c] != 16'hFFFF) model_cnt[c]++;
                            end else begin
                                mid_out[c] = 1;
                            end
                        end
                    end
                    if (in_valid[c] && in_ready[c]) begin
                        e.flit = in_flit[c*FW +: FW];
                        e.last = in_last[c];
                        if (in_first[c]) e.flit[31:27] = e.flit[23:19];
                        exp_q[c].push_back(e);
                        occ[c]++;
                        if (e.last) lasts[c]++;
                        in_first[c] = e.last;
                    end
                end
            end
            rst_last = !rst_n;
        end
    end

    // Present one flit (called just after a rising edge) and hold it until accepted.
    task automatic drive_flit(input int c, input logic [31:0] f, input bit last);
        int n;
        n = 0;
        in_flit[c*FW +: FW] = f;
        in_last[c]  = last;
        in_valid[c] = 1'b1;
        @(negedge clk);
        while (!in_ready[c] && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready[c]) check($sformatf("in_timeout ch%0d", c), 32'(in_ready[c]), 32'd1);
        @(posedge clk);
        #1;
        in_valid[c] = 1'b0;
        in_last[c]  = 1'b0;
    endtask

    task automatic send_pkt(input int c, input int len, input logic [4:0] src, input logic [4:0] dst);
        logic [31:0] f;
        for (int i = 0; i < len; i++) begin
            f = $urandom;
            if (i == 0) begin
                f[31:27] = dst;
                f[23:19] = src;
            end
            drive_flit(c, f, i == len - 1);
        end
    endtask

    task automatic burst(input int c, input int npkts);
        int g;
        for (int k = 0; k < npkts; k++) begin
            send_pkt(c, 2, 5'($urandom), 5'($urandom));
            g = $urandom_range(0, 3);
            repeat (g) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic wait_drain(input int c);
        int n;
        n = 0;
        while (exp_q[c].size() != 0 && n < 2000) begin
            @(posedge clk);
            n++;
        end
        check($sformatf("drain_left ch%0d", c), 32'(exp_q[c].size()), 32'd0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] f;
        repeat (2) @(posedge clk);
        #1;
        mon_en = 1'b1;
        rst_n  = 1'b1;
        @(posedge clk);
        #1;

        // Single-flit packet src=3 dest=0: one cycle to output, header swapped.
        rdy_mode[0] = 1;
        drive_flit(0, 32'h0018_0000, 1'b1);
        @(negedge clk);
        check("t1_latency_valid", 32'(out_valid[0]), 32'd1);
        check("t1_rewrite", out_flit[31:0], 32'h1818_0000);
        check("t1_last", 32'(out_last[0]), 32'd1);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("t1_pkt_count", 32'(pkt_count[15:0]), 32'd1);
        @(posedge clk);
        #1;

        // 4-flit packet held in FILL until its last flit arrives.
        reset_dut();
        rdy_mode[0] = 0;
        f = $urandom;
        f[31:27] = 5'd9;
        f[23:19] = 5'd4;
        drive_flit(0, f, 1'b0);
        drive_flit(0, $urandom, 1'b0);
        drive_flit(0, $urandom, 1'b0);
        @(negedge clk);
        check("t2_fill_blocked", 32'(out_valid[0]), 32'd0);
        @(posedge clk);
        #1;
        drive_flit(0, $urandom, 1'b1);
        @(negedge clk);
        check("t2_released", 32'(out_valid[0]), 32'd1);
        @(posedge clk);
        #1;
        rdy_mode[0] = 1;
        wait_drain(0);
        check("t2_pkt_count", 32'(pkt_count[15:0]), 32'd1);

        // 20-flit packet: buffer fills, cut-through drains once ready comes.
        reset_dut();
        rdy_mode[0] = 0;
        fork
            send_pkt(0, 20, 5'd1, 5'd6);
            begin
                repeat (30) @(posedge clk);
                @(negedge clk);
                check("t3_full_in_ready", 32'(in_ready[0]), 32'd0);
                check("t3_cut_through", 32'(out_valid[0]), 32'd1);
                rdy_mode[0] = 1;
            end
        join
        wait_drain(0);
        check("t3_draining_clear", 32'(dut.g_lane[0].u_fifo.draining), 32'd0);
        check("t3_pkt_count", 32'(pkt_count[15:0]), 32'd1);

        // Back-to-back 2-flit packets on both channels with random stalls.
        reset_dut();
        rdy_mode[0] = 2;
        rdy_mode[1] = 2;
        fork
            burst(0, 6);
            burst(1, 6);
        join
        rdy_mode[0] = 1;
        rdy_mode[1] = 1;
        wait_drain(0);
        wait_drain(1);
        check("t4_pkt_count0", 32'(pkt_count[15:0]), 32'd6);
        check("t4_pkt_count1", 32'(pkt_count[31:16]), 32'd6);

        // Reset with a partial packet buffered.
        reset_dut();
        rdy_mode[0] = 1;
        f = $urandom;
        f[31:27] = 5'd11;
        f[23:19] = 5'd2;
        drive_flit(0, f, 1'b0);
        drive_flit(0, $urandom, 1'b0);
        drive_flit(0, $urandom, 1'b0);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        check("t5_rst_out_valid", 32'(out_valid[0]), 32'd0);
        check("t5_rst_in_ready", 32'(in_ready[0]), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        check("t5_rel_in_ready", 32'(in_ready[0]), 32'd1);
        check("t5_rel_pkt_count", 32'(pkt_count[15:0]), 32'd0);
        @(posedge clk);
        #1;
        send_pkt(0, 1, 5'd7, 5'd2);
        wait_drain(0);
        check("t5_pkt_count", 32'(pkt_count[15:0]), 32'd1);

        // Counter saturation from a forced near-maximum value.
        force dut.g_lane[0].pkt_cnt_q = 16'hFFFE;
        model_cnt[0] = 16'hFFFE;
        #1;
        release dut.g_lane[0].pkt_cnt_q;
        rdy_mode[0] = 1;
        send_pkt(0, 1, 5'd3, 5'd5);
        send_pkt(0, 1, 5'd3, 5'd5);
        send_pkt(0, 1, 5'd3, 5'd5);
        wait_drain(0);
        check("t6_pkt_count_sat", 32'(pkt_count[15:0]), 32'h0000_FFFF);

        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
